vram_cpu_port: RTL and testbench

CPU-side access adapter that sits directly upstream of the 32-bit dual-port VRAM bank and drives one of its ports. It turns ARM7 8/16/32-bit bus requests into whole-word RAM transactions, because the RAM has only a single word-wide write enable. Sub-word writes use read-modify-write. It also applies the GBA VRAM byte-write rules:

- In the BG region, a byte is duplicated into both bytes of the addressed halfword.
- In the OBJ region, byte writes are dropped.

---
 rtl/vram_cpu_port.sv | 118 +++++++++++
 tb/tb_vram_cpu_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_port.sv
// CPU-side adapter for one port of the 32-bit VRAM bank. Turns 8/16/32-bit
// requests into whole-word accesses, using read-modify-write for sub-word writes.
module vram_cpu_port #(
  parameter int          AW       = 14,
  parameter int unsigned OBJ_BASE = 32'h8000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic [AW+1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_ack,
  output logic [31:0]   cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  localparam logic [AW+1:0] OBJ_LIM = OBJ_BASE[AW+1:0];

  // Handshake: cpu_req is a one-cycle pulse honoured only while cpu_busy=0;
  // cpu_ack pulses for exactly one cycle when the transaction completes.
  logic [1:0]    state;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rbuf;
  logic [31:0]   merged;
  logic [31:0]   rd_fmt;

  // Word to be written back: new lanes from wdata_q, everything else from rbuf.
  always_comb begin
    merged = rbuf;
    if (size_q[1]) begin
      merged = wdata_q;
    end else if (size_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      if (addr_q[1]) merged[31:16] = {wdata_q[7:0], wdata_q[7:0]};
      else           merged[15:0]  = {wdata_q[7:0], wdata_q[7:0]};
    end
  end

  // Read formatting works on mem_dout directly, the same value rbuf captures.
  always_comb begin
    rd_fmt = mem_dout;
    if (size_q == 2'd1) begin
      rd_fmt = addr_q[1] ? {16'h0, mem_dout[31:16]} : {16'h0, mem_dout[15:0]};
    end else if (size_q == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    rd_fmt = {24'h0, mem_dout[7:0]};
        2'd1:    rd_fmt = {24'h0, mem_dout[15:8]};
        2'd2:    rd_fmt = {24'h0, mem_dout[23:16]};
        default: rd_fmt = {24'h0, mem_dout[31:24]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rbuf      <= 32'h0;
      cpu_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            size_q  <= cpu_size;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            if (!cpu_we)
              state <= S_RD;
            else if (cpu_size[1])
              state <= S_WR;
            else if (cpu_size == 2'd0 && cpu_addr >= OBJ_LIM)
              state <= S_ACK;  // OBJ byte write: silently dropped
            else
              state <= S_RD;
          end
        end
        S_RD: begin
          rbuf <= mem_dout;
          if (we_q) begin
            state <= S_WR;
          end else begin
            cpu_rdata <= rd_fmt;
            state     <= S_ACK;
          end
        end
        S_WR:    state <= S_ACK;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpu_busy = (state != S_IDLE);
  assign cpu_ack  = (state == S_ACK);
  assign mem_addr = addr_q[AW+1:2];
  assign mem_we   = (state == S_WR);
  assign mem_din  = (state == S_WR) ? merged : 32'h0;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Bench for vram_cpu_port: RAM model on the memory port, array-based reference
// model at issue time, and a monitor that scores acks and RAM writes.
module tb_vram_cpu_port;
  localparam int AW = 14;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_size;
  logic [AW+1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [31:0]   cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  vram_cpu_port #(.AW(AW), .OBJ_BASE(32'h8000)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram     [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];
  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_din;

  // ---------------- scoreboard ----------------
  // exp_q entry: [63] read, [57:56] latency, [55:32] issue cycle, [31:0] rdata
  logic [63:0] exp_q[$];
  // wexp_q entry: [45:32] word address, [31:0] written word
  logic [45:0] wexp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [63:0] mon_e;
  logic [45:0] mon_w;
  always @(negedge clk) begin
    if (rst === 1'b0 && cpu_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_latency", cyc - {8'h0, mon_e[55:32]}, {30'h0, mon_e[57:56]});
        if (mon_e[63]) chk("rdata", cpu_rdata, mon_e[31:0]);
      end
    end
    if (rst === 1'b0 && mem_we) begin
      if (wexp_q.size() == 0) begin
        chk("unexpected_write", {18'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_w = wexp_q.pop_front();
        chk("mem_addr", {18'h0, mem_addr}, {18'h0, mon_w[45:32]});
        chk("mem_din", mem_din, mon_w[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for idle; while busy, throws junk request pulses that must be ignored.
  task automatic wait_idle();
    int n = 0;
    while (cpu_busy) begin
      if (n > 30) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wait_idle: busy stuck for %0d cycles", n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
      end
      cpu_req   = ($urandom_range(0, 2) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_size  = 2'($urandom_range(0, 3));
      cpu_addr  = 16'($urandom_range(0, 65535));
      cpu_wdata = $urandom;
      @(posedge clk); #1;
      n++;
    end
    cpu_req = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [1:0] size,
                        input logic [15:0] addr, input logic [31:0] wd);
    logic [31:0] old;
    logic [31:0] nw;
    logic [31:0] rd;
    logic [15:0] half;
    logic [13:0] wa;
    int lat;
    int sh;
    wait_idle();
    wa  = addr[15:2];
    old = ref_mem[wa];
    rd  = 32'h0;
    if (!we) begin
      lat = 2;
      if (size >= 2)      rd = old;
      else if (size == 1) rd = (old >> (16 * addr[1])) & 32'hFFFF;
      else                rd = (old >> (8 * addr[1:0])) & 32'hFF;
    end else if (size == 0 && addr >= 16'h8000) begin
      lat = 1;
    end else begin
      if (size >= 2) begin
        nw  = wd;
        lat = 2;
      end else begin
        sh   = 16 * addr[1];
        half = (size == 1) ? wd[15:0] : {wd[7:0], wd[7:0]};
        nw   = (old & ~(32'hFFFF << sh)) | ({16'h0, half} << sh);
        lat  = 3;
      end
      wexp_q.push_back({wa, nw});
      ref_mem[wa] = nw;
    end
    exp_q.push_back({~we, 5'h0, lat[1:0], cyc[23:0], rd});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cpu_busy) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int bad;
  initial begin
    for (int i = 0; i < NW; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0;
    cpu_addr = '0; cpu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, cpu_busy}, 32'h0);
    chk("rst_ack", {31'h0, cpu_ack}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", {18'h0, mem_addr}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // word write then read
    do_txn(1'b1, 2'd2, 16'h0104, 32'hDEADBEEF);
    do_txn(1'b0, 2'd2, 16'h0104, 32'h0);
    drain();
    chk("word_rd_value", cpu_rdata, 32'hDEADBEEF);

    // halfword RMW
    do_txn(1'b1, 2'd2, 16'h0200, 32'h11223344);
    do_txn(1'b1, 2'd1, 16'h0202, 32'h0000ABCD);
    do_txn(1'b0, 2'd1, 16'h0200, 32'h0);
    drain();
    chk("hw_rmw_word", ram[14'h0080], 32'hABCD3344);
    chk("hw_rd_value", cpu_rdata, 32'h00003344);

    // BG byte duplication
    do_txn(1'b1, 2'd2, 16'h0300, 32'h11223344);
    do_txn(1'b1, 2'd0, 16'h0301, 32'h0000005A);
    do_txn(1'b0, 2'd0, 16'h0303, 32'h0);
    drain();
    chk("bg_byte_word", ram[14'h00C0], 32'h11225A5A);
    chk("bg_byte_rd", cpu_rdata, 32'h00000011);

    // OBJ byte drop, halfword still performed
    do_txn(1'b1, 2'd2, 16'h8000, 32'hCAFEF00D);
    do_txn(1'b1, 2'd0, 16'h8000, 32'h000000FF);
    drain();
    chk("obj_byte_dropped", ram[14'h2000], 32'hCAFEF00D);
    do_txn(1'b1, 2'd1, 16'h8000, 32'h00001234);
    drain();
    chk("obj_hw_written", ram[14'h2000], 32'hCAFE1234);

    // reset during the RD cycle of a BG byte write
    wait_idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd0;
    cpu_addr = 16'h0301; cpu_wdata = 32'h00000077;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, cpu_busy}, 32'h0);
    chk("midrst_ack", {31'h0, cpu_ack}, 32'h0);
    chk("midrst_rdata", cpu_rdata, 32'h0);
    chk("midrst_mem_addr", {18'h0, mem_addr}, 32'h0);
    chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("midrst_mem_din", mem_din, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_write", ram[14'h00C0], 32'h11225A5A);
    do_txn(1'b0, 2'd2, 16'h0300, 32'h0);
    drain();

    // randomized mix over a small BG window and a small OBJ window
    for (int i = 0; i < 300; i++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'(($urandom_range(0, 1) ? 32'h8000 : 32'h0000) + $urandom_range(0, 31)),
             $urandom);
    end
    drain();
    chk("writes_pending", wexp_q.size(), 32'd0);

    bad = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_final_diffs", bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
